// File: rtl/reg_cpu_if.sv
// reg_cpu register bus: single-cycle CPU requests out, read data and
// read-valid back to the initiator.
interface reg_cpu_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          reg_cpu_cs;
    logic [AW-1:0] reg_cpu_addr;
    logic [DW-1:0] reg_cpu_wr_data;
    logic          reg_cpu_we;
    logic          reg_cpu_re;
    logic [DW-1:0] reg_cpu_rd_data;
    logic          reg_cpu_rdv;

    modport master (
        output reg_cpu_cs, reg_cpu_addr, reg_cpu_wr_data, reg_cpu_we, reg_cpu_re,
        input  reg_cpu_rd_data, reg_cpu_rdv
    );

    modport slave (
        input  reg_cpu_cs, reg_cpu_addr, reg_cpu_wr_data, reg_cpu_we, reg_cpu_re,
        output reg_cpu_rd_data, reg_cpu_rdv
    );
endinterface

// File: rtl/reg_cpu_slave.sv
// reg_cpu responder serving the image-pipe register bank (CTRL, STATUS,
// IMG_SIZE, IRQ, SCRATCH). Optional TIMESTAMP at 0x18 via REG_CPU_SLAVE_TIMESTAMP_EN.
module reg_cpu_slave #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic        reg_cpu_clk,
    input  logic        rst_n,
    reg_cpu_if.slave    bus,
    input  logic        busy_i,
    input  logic [7:0]  irq_set_i,
    output logic        ctrl_enable_o,
    output logic        ctrl_soft_rst_o,
    output logic [3:0]  ctrl_mode_o,
    output logic [15:0] img_width_o,
    output logic [15:0] img_height_o,
    output logic        irq_o
);
    localparam logic [5:0] IDX_CTRL   = 6'h00;
    localparam logic [5:0] IDX_STATUS = 6'h01;
    localparam logic [5:0] IDX_IMG    = 6'h02;
    localparam logic [5:0] IDX_STAT   = 6'h03;
    localparam logic [5:0] IDX_MASK   = 6'h04;
    localparam logic [5:0] IDX_SCR    = 6'h05;
    localparam logic [5:0] IDX_TS     = 6'h06;
    localparam logic [DW-1:0] UNMAPPED = 32'hDEAD_BEEF;

    logic          hit;
    logic [5:0]    idx;
    logic          wr_en;
    logic          rd_req;
    logic [DW-1:0] rdata;
    logic          unused_addr;

    logic          ctrl_en_q, ctrl_en_d;
    logic [3:0]    ctrl_mode_q, ctrl_mode_d;
    logic          soft_rst_q, soft_rst_d;
    logic [DW-1:0] img_size_q, img_size_d;
    logic [7:0]    irq_stat_q, irq_stat_d;
    logic [7:0]    irq_mask_q, irq_mask_d;
    logic [DW-1:0] scratch_q, scratch_d;
    logic          irq_q, irq_d;

    logic [RD_LAT-1:0] rd_vld_q;
    logic [DW-1:0]     rd_data_q [RD_LAT];

    assign hit         = (bus.reg_cpu_addr[AW-1:8] == '0);
    assign idx         = bus.reg_cpu_addr[7:2];
    assign wr_en       = bus.reg_cpu_cs & bus.reg_cpu_we & hit;
    assign rd_req      = bus.reg_cpu_cs & bus.reg_cpu_re & ~bus.reg_cpu_we;
    assign unused_addr = ^bus.reg_cpu_addr[1:0];

`ifdef REG_CPU_SLAVE_TIMESTAMP_EN
    logic [DW-1:0] ts_q, ts_d;

    // The clearing write edge itself loads 0, counting resumes on the next edge.
    assign ts_d = (wr_en && idx == IDX_TS) ? '0 : ts_q + DW'(1);

    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`endif

    // Snapshot of pre-update register values; soft-reset bit always reads 0.
    always_comb begin
        rdata = UNMAPPED;
        if (hit) begin
            case (idx)
                IDX_CTRL:   rdata = {24'b0, ctrl_mode_q, 3'b0, ctrl_en_q};
                IDX_STATUS: rdata = {{(DW-1){1'b0}}, busy_i};
                IDX_IMG:    rdata = img_size_q;
                IDX_STAT:   rdata = {24'b0, irq_stat_q};
                IDX_MASK:   rdata = {24'b0, irq_mask_q};
                IDX_SCR:    rdata = scratch_q;
`ifdef REG_CPU_SLAVE_TIMESTAMP_EN
                IDX_TS:     rdata = ts_q;
`endif
                default:    rdata = UNMAPPED;
            endcase
        end
    end

    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        soft_rst_d  = 1'b0;
        img_size_d  = img_size_q;
        irq_mask_d  = irq_mask_q;
        scratch_d   = scratch_q;
        irq_stat_d  = irq_stat_q;
        irq_d       = |(irq_stat_q & irq_mask_q);
        if (wr_en) begin
            case (idx)
                IDX_CTRL: begin
                    ctrl_en_d   = bus.reg_cpu_wr_data[0];
                    soft_rst_d  = bus.reg_cpu_wr_data[1];
                    ctrl_mode_d = bus.reg_cpu_wr_data[7:4];
                end
                IDX_IMG:  img_size_d = bus.reg_cpu_wr_data;
                IDX_STAT: irq_stat_d = irq_stat_q & ~bus.reg_cpu_wr_data[7:0];
                IDX_MASK: irq_mask_d = bus.reg_cpu_wr_data[7:0];
                IDX_SCR:  scratch_d  = bus.reg_cpu_wr_data;
                default:  ;
            endcase
        end
        // New events override a same-cycle W1C.
        irq_stat_d = irq_stat_d | irq_set_i;
    end

    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= '0;
            soft_rst_q  <= 1'b0;
            img_size_q  <= '0;
            irq_stat_q  <= '0;
            irq_mask_q  <= '0;
            scratch_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            soft_rst_q  <= soft_rst_d;
            img_size_q  <= img_size_d;
            irq_stat_q  <= irq_stat_d;
            irq_mask_q  <= irq_mask_d;
            scratch_q   <= scratch_d;
            irq_q       <= irq_d;
        end
    end

    // Read pipeline: data held at 0 when its valid is low so the bus sees 0 between responses.
    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_data_q[i] <= '0;
        end else begin
            rd_vld_q[0]  <= rd_req;
            rd_data_q[0] <= rd_req ? rdata : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_data_q[i] <= rd_data_q[i-1];
            end
        end
    end

    assign bus.reg_cpu_rdv     = rd_vld_q[RD_LAT-1];
    assign bus.reg_cpu_rd_data = rd_data_q[RD_LAT-1];
    assign ctrl_enable_o       = ctrl_en_q;
    assign ctrl_soft_rst_o     = soft_rst_q;
    assign ctrl_mode_o         = ctrl_mode_q;
    assign img_width_o         = img_size_q[15:0];
    assign img_height_o        = img_size_q[31:16];
    assign irq_o               = irq_q;
endmodule

// File: tb/tb_reg_cpu_slave.sv
// Bench for reg_cpu_slave: two instances (RD_LAT=1 and RD_LAT=4) share one
// stimulus stream; a scoreboard per instance checks read data and arrival cycle.
module tb_reg_cpu_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] irq_set = 8'h00;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    reg_cpu_if #(.DW(32), .AW(32)) b1 ();
    reg_cpu_if #(.DW(32), .AW(32)) b4 ();

    logic        en1, sr1, irq1, en4, sr4, irq4;
    logic [3:0]  mode1, mode4;
    logic [15:0] w1, h1, w4, h4;

    assign b4.reg_cpu_cs      = b1.reg_cpu_cs;
    assign b4.reg_cpu_addr    = b1.reg_cpu_addr;
    assign b4.reg_cpu_wr_data = b1.reg_cpu_wr_data;
    assign b4.reg_cpu_we      = b1.reg_cpu_we;
    assign b4.reg_cpu_re      = b1.reg_cpu_re;

    reg_cpu_slave #(.DW(32), .AW(32), .RD_LAT(1)) dut1 (
        .reg_cpu_clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy_i(busy),
        .irq_set_i(irq_set), .ctrl_enable_o(en1), .ctrl_soft_rst_o(sr1),
        .ctrl_mode_o(mode1), .img_width_o(w1), .img_height_o(h1), .irq_o(irq1)
    );

    reg_cpu_slave #(.DW(32), .AW(32), .RD_LAT(4)) dut4 (
        .reg_cpu_clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy_i(busy),
        .irq_set_i(irq_set), .ctrl_enable_o(en4), .ctrl_soft_rst_o(sr4),
        .ctrl_mode_o(mode4), .img_width_o(w4), .img_height_o(h4), .irq_o(irq4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every rdv must match the oldest pending read in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        n_cmp++;
        if (b1.reg_cpu_rdv === 1'b1) begin
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL rdv_unexpected_L1 cyc=%0d got data %h, required no rdv", cyc, b1.reg_cpu_rd_data);
            end else begin
                e = q1.pop_front();
                if (b1.reg_cpu_rd_data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_L1 got %h at cyc %0d, required %h at cyc %0d", b1.reg_cpu_rd_data, cyc, e.data, e.due);
                end
            end
        end else if (b1.reg_cpu_rdv !== 1'b0 || b1.reg_cpu_rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_L1 cyc=%0d got rdv=%b data=%h, required rdv=0 data=0", cyc, b1.reg_cpu_rdv, b1.reg_cpu_rd_data);
        end
        n_cmp++;
        if (b4.reg_cpu_rdv === 1'b1) begin
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL rdv_unexpected_L4 cyc=%0d got data %h, required no rdv", cyc, b4.reg_cpu_rd_data);
            end else begin
                e = q4.pop_front();
                if (b4.reg_cpu_rd_data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_L4 got %h at cyc %0d, required %h at cyc %0d", b4.reg_cpu_rd_data, cyc, e.data, e.due);
                end
            end
        end else if (b4.reg_cpu_rdv !== 1'b0 || b4.reg_cpu_rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_L4 cyc=%0d got rdv=%b data=%h, required rdv=0 data=0", cyc, b4.reg_cpu_rdv, b4.reg_cpu_rd_data);
        end
    end

    task automatic idle_bus();
        b1.reg_cpu_cs      = 1'b0;
        b1.reg_cpu_we      = 1'b0;
        b1.reg_cpu_re      = 1'b0;
        b1.reg_cpu_addr    = '0;
        b1.reg_cpu_wr_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
        b1.reg_cpu_cs      = 1'b1;
        b1.reg_cpu_we      = 1'b1;
        b1.reg_cpu_re      = 1'b0;
        b1.reg_cpu_addr    = addr;
        b1.reg_cpu_wr_data = data;
        step();
        idle_bus();
    endtask

    task automatic read_reg(input logic [31:0] addr, input logic [31:0] exp_data);
        exp_t e;
        b1.reg_cpu_cs   = 1'b1;
        b1.reg_cpu_we   = 1'b0;
        b1.reg_cpu_re   = 1'b1;
        b1.reg_cpu_addr = addr;
        e.data = exp_data;
        e.due  = cyc + 1;
        q1.push_back(e);
        e.due  = cyc + 4;
        q4.push_back(e);
        step();
        idle_bus();
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q1.size() == 0 && q4.size() == 0) break;
            step();
        end
        n_cmp++;
        if (q1.size() != 0 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending L1=%0d L4=%0d, required 0/0", q1.size(), q4.size());
            q1.delete();
            q4.delete();
        end
    endtask

    task automatic test_reset();
        idle_bus();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({en1, sr1, mode1, w1, h1, irq1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_L1 got %h, required 0", {en1, sr1, mode1, w1, h1, irq1});
        end
        n_cmp++;
        if ({en4, sr4, mode4, w4, h4, irq4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_L4 got %h, required 0", {en4, sr4, mode4, w4, h4, irq4});
        end
        rst_n = 1'b1;
        step();
        read_reg(32'h00, 32'h0);
        read_reg(32'h08, 32'h0);
        read_reg(32'h0C, 32'h0);
        read_reg(32'h10, 32'h0);
        read_reg(32'h14, 32'h0);
        drain();
    endtask

    task automatic test_scratch();
        write_reg(32'h14, 32'hA5A5_5A5A);
        read_reg(32'h14, 32'hA5A5_5A5A);
        drain();
        read_reg(32'h17, 32'hA5A5_5A5A);
        drain();
    endtask

    task automatic test_ctrl();
        write_reg(32'h00, 32'h0000_0033);
        n_cmp++;
        if ({en1, mode1, sr1, en4, mode4, sr4} !== {1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1}) begin
            n_fail++;
            $display("FAIL ctrl_after_write got en=%b mode=%h srst=%b, required en=1 mode=3 srst=1", en1, mode1, sr1);
        end
        step();
        n_cmp++;
        if ({en1, sr1, sr4} !== 3'b100) begin
            n_fail++;
            $display("FAIL ctrl_srst_pulse got en=%b srst=%b/%b, required en=1 srst=0/0", en1, sr1, sr4);
        end
        read_reg(32'h00, 32'h0000_0031);
        drain();
    endtask

    task automatic test_irq();
        write_reg(32'h10, 32'h0000_0004);
        irq_set = 8'h05;
        step();
        irq_set = 8'h00;
        n_cmp++;
        if (irq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_registered got %b, required 0 in the edge of the set", irq1);
        end
        step();
        n_cmp++;
        if ({irq1, irq4} !== 2'b11) begin
            n_fail++;
            $display("FAIL irq_assert got %b%b, required 11", irq1, irq4);
        end
        irq_set = 8'h04;
        write_reg(32'h0C, 32'h0000_0004);
        irq_set = 8'h00;
        read_reg(32'h0C, 32'h0000_0005);
        n_cmp++;
        if (irq1 !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set_wins got %b, required 1", irq1);
        end
        write_reg(32'h0C, 32'h0000_0004);
        step();
        n_cmp++;
        if ({irq1, irq4} !== 2'b00) begin
            n_fail++;
            $display("FAIL irq_clear got %b%b, required 00", irq1, irq4);
        end
        read_reg(32'h0C, 32'h0000_0001);
        irq_set = 8'h80;
        read_reg(32'h0C, 32'h0000_0001);
        irq_set = 8'h00;
        read_reg(32'h0C, 32'h0000_0081);
        read_reg(32'h10, 32'h0000_0004);
        drain();
    endtask

    task automatic test_back_to_back();
        busy = 1'b1;
        write_reg(32'h08, 32'h0123_4567);
        n_cmp++;
        if ({h1, w1} !== 32'h0123_4567) begin
            n_fail++;
            $display("FAIL img_size_outputs got h=%h w=%h, required h=0123 w=4567", h1, w1);
        end
        read_reg(32'h08, 32'h0123_4567);
        read_reg(32'h14, 32'hA5A5_5A5A);
        read_reg(32'h40, 32'hDEAD_BEEF);
        read_reg(32'h04, 32'h0000_0001);
        read_reg(32'h104, 32'hDEAD_BEEF);
        drain();
        busy = 1'b0;
        b1.reg_cpu_cs      = 1'b1;
        b1.reg_cpu_we      = 1'b1;
        b1.reg_cpu_re      = 1'b1;
        b1.reg_cpu_addr    = 32'h14;
        b1.reg_cpu_wr_data = 32'h1111_2222;
        step();
        idle_bus();
        b1.reg_cpu_we      = 1'b1;
        b1.reg_cpu_addr    = 32'h14;
        b1.reg_cpu_wr_data = 32'hFFFF_FFFF;
        step();
        idle_bus();
        repeat (5) step();
        read_reg(32'h14, 32'h1111_2222);
        read_reg(32'h04, 32'h0000_0000);
        drain();
    endtask

    task automatic test_timestamp();
`ifdef REG_CPU_SLAVE_TIMESTAMP_EN
        write_reg(32'h18, 32'h1234_5678);
        repeat (9) step();
        read_reg(32'h18, 32'h0000_0009);
`else
        read_reg(32'h18, 32'hDEAD_BEEF);
`endif
        drain();
    endtask

    task automatic test_reset_mid_read();
        b1.reg_cpu_cs   = 1'b1;
        b1.reg_cpu_re   = 1'b1;
        b1.reg_cpu_addr = 32'h14;
        step();
        idle_bus();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({b1.reg_cpu_rdv, b4.reg_cpu_rdv} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_read got rdv %b%b, required 00", b1.reg_cpu_rdv, b4.reg_cpu_rdv);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (6) step();
        n_cmp++;
        if ({en1, irq1} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_regs got en=%b irq=%b, required 0 0", en1, irq1);
        end
        read_reg(32'h14, 32'h0);
        read_reg(32'h0C, 32'h0);
        drain();
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_scratch();
        test_ctrl();
        test_irq();
        test_back_to_back();
        test_timestamp();
        test_reset_mid_read();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
